clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider with 50 % duty cycle for both even and odd ratios. It is the general successor to the team's fixed even-ratio divider. The division ratio is loaded over a simple strobe interface and takes effect glitch-free at the next period boundary. An enable parks the output low between periods. A per-period tick is provided for synchronous logic in the source domain. It sits in the clock-generation area, driving low-speed peripheral and strobe clocks from the system clock.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_halfstage.sv | 20 ++
 rtl/clk_div_prog.sv | 118 +++++++++++
 tb/tb_clk_div_prog.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_DIV = 2;

    // High-phase length in source cycles (rounded up for odd N).
    function automatic int unsigned half_of(input int unsigned n);
        return (n + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_halfstage.sv
// Negedge retiming flop and output select; the only falling-edge logic of the divider.
module clk_div_halfstage (
    input  logic clk,
    input  logic rst_n,
    input  logic p,
    input  logic odd_sel,
    output logic clk_out
);

    logic n;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) n <= 1'b0;
        else        n <= p;
    end

    // odd_sel only changes at a boundary, when p and n are both low.
    assign clk_out = odd_sel ? (p & n) : p;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50% duty clock divider with shadowed divisor and boundary apply.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             pending,
    output logic             clamped
);

    localparam logic [WIDTH-1:0] DEF_DIV   = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic             p, p_nxt;
    logic [WIDTH-1:0] div_act, div_shd;
    logic             odd_act;

    logic [WIDTH-1:0] ld_val, last_cnt, new_div;
    logic [WIDTH:0]   half, cnt_inc;
    logic             at_last, boundary, apply;

    assign ld_val   = (div_val < MIN_DIV_W) ? MIN_DIV_W : div_val;
    assign last_cnt = div_act - WIDTH'(1);
    assign half     = (WIDTH+1)'(half_of(32'(div_act)));
    assign cnt_inc  = {1'b0, cnt} + (WIDTH+1)'(1);
    assign at_last  = (state == RUN) && (cnt == last_cnt);
    assign boundary = at_last || ((state == IDLE) && en);
    assign apply    = boundary && (div_load || pending);
    // A load landing on the boundary edge wins over the shadow value.
    assign new_div  = div_load ? ld_val : div_shd;
    assign tick     = at_last;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        p_nxt     = p;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                p_nxt   = 1'b0;
                if (en) begin
                    state_nxt = RUN;
                    p_nxt     = 1'b1;
                end
            end
            RUN: begin
                if (at_last) begin
                    cnt_nxt = '0;
                    if (en) begin
                        p_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        p_nxt     = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt_inc[WIDTH-1:0];
                    p_nxt   = (cnt_inc < half);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                p_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            p     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            p     <= p_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_act <= DEF_DIV;
            div_shd <= DEF_DIV;
            odd_act <= DEF_DIV[0];
            pending <= 1'b0;
            clamped <= 1'b0;
        end else begin
            clamped <= div_load && (div_val < MIN_DIV_W);
            if (div_load) div_shd <= ld_val;
            if (apply) begin
                div_act <= new_div;
                odd_act <= new_div[0];
                pending <= 1'b0;
            end else if (div_load) begin
                pending <= 1'b1;
            end
        end
    end

    clk_div_halfstage u_halfstage (
        .clk     (clk),
        .rst_n   (rst_n),
        .p       (p),
        .odd_sel (odd_act),
        .clk_out (clk_out)
    );

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       div_load = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       clk_out, tick, pending, clamped;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int rise_cnt = 0;

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending),
        .clamped  (clamped)
    );

    always #5 clk = ~clk;

    always @(posedge clk_out) rise_cnt++;

    // Reset, then start running; leaves us 1 ns after the posedge of cnt=0.
    task automatic restart(input logic do_load, input logic [7:0] nval);
        rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_val = 8'd0;
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b1; div_load = do_load; div_val = nval;
        @(posedge clk); #1;
        div_load = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst_n = 1'b0; en = 1'b1; div_load = 1'b1; div_val = 8'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            got = {clk_out, tick, pending, clamped};
            chk_cnt++;
            if (got !== 4'b0000) $display("FAIL reset_pos i=%0d got=%b exp=0000", i, got);
            else pass_cnt++;
            @(negedge clk); #1;
            got = {clk_out, tick, pending, clamped};
            chk_cnt++;
            if (got !== 4'b0000) $display("FAIL reset_neg i=%0d got=%b exp=0000", i, got);
            else pass_cnt++;
        end
        en = 1'b0; div_load = 1'b0;
    endtask

    task automatic test_default();
        logic [2:0] e;
        int c;
        restart(1'b0, 8'd0);
        for (int k = 0; k < 20; k++) begin
            c = k % 10;
            e = {c < 5, c == 9, 1'b0};
            chk_cnt++;
            if ({clk_out, tick, pending} !== e)
                $display("FAIL default k=%0d got=%b exp=%b", k, {clk_out, tick, pending}, e);
            else pass_cnt++;
            @(negedge clk); #1;
            chk_cnt++;
            if (clk_out !== (c < 5)) $display("FAIL default_neg k=%0d got=%b exp=%b", k, clk_out, c < 5);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_odd();
        logic [2:0] e;
        int c;
        restart(1'b0, 8'd0);
        for (int k = 0; k < 10; k++) begin
            e = {k < 5, k == 9, k >= 3};
            chk_cnt++;
            if ({clk_out, tick, pending} !== e)
                $display("FAIL odd_n10 k=%0d got=%b exp=%b", k, {clk_out, tick, pending}, e);
            else pass_cnt++;
            if (k == 2) begin div_load = 1'b1; div_val = 8'd3; end
            if (k == 3) div_load = 1'b0;
            @(posedge clk); #1;
        end
        for (int j = 0; j < 6; j++) begin
            c = j % 3;
            e = {c == 1, c == 2, j >= 4};
            chk_cnt++;
            if ({clk_out, tick, pending} !== e)
                $display("FAIL odd_n3 j=%0d got=%b exp=%b", j, {clk_out, tick, pending}, e);
            else pass_cnt++;
            if (j == 3) begin div_load = 1'b1; div_val = 8'd5; end
            if (j == 4) div_load = 1'b0;
            @(negedge clk); #1;
            chk_cnt++;
            if (clk_out !== (c < 2)) $display("FAIL odd_n3_neg j=%0d got=%b exp=%b", j, clk_out, c < 2);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        for (int j = 0; j < 10; j++) begin
            c = j % 5;
            e = {(c >= 1) && (c < 3), c == 4, 1'b0};
            chk_cnt++;
            if ({clk_out, tick, pending} !== e)
                $display("FAIL odd_n5 j=%0d got=%b exp=%b", j, {clk_out, tick, pending}, e);
            else pass_cnt++;
            @(negedge clk); #1;
            chk_cnt++;
            if (clk_out !== (c < 3)) $display("FAIL odd_n5_neg j=%0d got=%b exp=%b", j, clk_out, c < 3);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_clamp();
        logic [3:0] e;
        int c;
        restart(1'b1, 8'd0);
        for (int j = 0; j < 8; j++) begin
            c = j % 2;
            e = {c == 0, c == 1, j == 5, (j == 0) || (j == 5)};
            chk_cnt++;
            if ({clk_out, tick, pending, clamped} !== e)
                $display("FAIL clamp j=%0d got=%b exp=%b", j, {clk_out, tick, pending, clamped}, e);
            else pass_cnt++;
            if (j == 4) begin div_load = 1'b1; div_val = 8'd1; end
            if (j == 5) div_load = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_enable();
        logic [1:0] e;
        restart(1'b1, 8'd6);
        for (int k = 0; k < 6; k++) begin
            e = {k < 3, k == 5};
            chk_cnt++;
            if ({clk_out, tick} !== e) $display("FAIL en_drop k=%0d got=%b exp=%b", k, {clk_out, tick}, e);
            else pass_cnt++;
            if (k == 2) en = 1'b0;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if ({clk_out, tick} !== 2'b00) $display("FAIL en_idle k=%0d got=%b exp=00", k, {clk_out, tick});
            else pass_cnt++;
            if (k == 3) en = 1'b1;
            @(negedge clk); #1;
            chk_cnt++;
            if (clk_out !== 1'b0) $display("FAIL en_idle_neg k=%0d got=%b exp=0", k, clk_out);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 6; k++) begin
            e = {k < 3, k == 5};
            chk_cnt++;
            if ({clk_out, tick} !== e) $display("FAIL en_restart k=%0d got=%b exp=%b", k, {clk_out, tick}, e);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        int c;
        restart(1'b0, 8'd0);
        for (int k = 0; k < 10; k++) begin
            e = {k < 5, k == 9, k >= 2};
            chk_cnt++;
            if ({clk_out, tick, pending} !== e)
                $display("FAIL b2b_n10 k=%0d got=%b exp=%b", k, {clk_out, tick, pending}, e);
            else pass_cnt++;
            if (k == 1) begin div_load = 1'b1; div_val = 8'd4; end
            if (k == 2) div_val = 8'd7;
            if (k == 3) div_load = 1'b0;
            @(posedge clk); #1;
        end
        for (int j = 0; j < 14; j++) begin
            c = j % 7;
            e = {(c >= 1) && (c < 4), c == 6, 1'b0};
            chk_cnt++;
            if ({clk_out, tick, pending} !== e)
                $display("FAIL b2b_n7 j=%0d got=%b exp=%b", j, {clk_out, tick, pending}, e);
            else pass_cnt++;
            @(negedge clk); #1;
            chk_cnt++;
            if (clk_out !== (c < 4)) $display("FAIL b2b_n7_neg j=%0d got=%b exp=%b", j, clk_out, c < 4);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_boundary();
        int nseq[3] = '{4, 5, 4};
        int base, nv, h;
        logic pe;
        logic [2:0] e;
        restart(1'b1, 8'd4);
        base = rise_cnt;
        for (int i = 0; i < 3; i++) begin
            nv = nseq[i];
            h  = (nv + 1) / 2;
            for (int c = 0; c < nv; c++) begin
                pe = (nv % 2 == 1) ? ((c >= 1) && (c < h)) : (c < h);
                e  = {pe, c == nv - 1, 1'b0};
                chk_cnt++;
                if ({clk_out, tick, pending} !== e)
                    $display("FAIL bnd i=%0d c=%0d got=%b exp=%b", i, c, {clk_out, tick, pending}, e);
                else pass_cnt++;
                if (c == 0) div_load = 1'b0;
                if ((c == nv - 1) && (i < 2)) begin
                    div_load = 1'b1;
                    div_val  = 8'(nseq[i+1]);
                end
                @(negedge clk); #1;
                chk_cnt++;
                if (clk_out !== (c < h)) $display("FAIL bnd_neg i=%0d c=%0d got=%b exp=%b", i, c, clk_out, c < h);
                else pass_cnt++;
                @(posedge clk); #1;
            end
        end
        chk_cnt++;
        if ((rise_cnt - base) !== 3) $display("FAIL bnd_rises got=%0d exp=3", rise_cnt - base);
        else pass_cnt++;
        chk_cnt++;
        if (clk_out !== 1'b1) $display("FAIL bnd_next_start got=%b exp=1", clk_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        restart(1'b1, 8'd4);
        chk_cnt++;
        if (clk_out !== 1'b1) $display("FAIL rmid_pre got=%b exp=1", clk_out);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({clk_out, tick} !== 2'b00) $display("FAIL rmid_async got=%b exp=00", {clk_out, tick});
        else pass_cnt++;
        en = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (clk_out !== 1'b0) $display("FAIL rmid_post k=%0d got=%b exp=0", k, clk_out);
            else pass_cnt++;
            @(negedge clk); #1;
            chk_cnt++;
            if (clk_out !== 1'b0) $display("FAIL rmid_post_neg k=%0d got=%b exp=0", k, clk_out);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_load_odd();
        test_clamp();
        test_enable();
        test_back_to_back();
        test_boundary();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
